fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the pipelined CPU. It sits directly around the program-counter register. It drives the PC register's next-value input, fetches from instruction memory at the PC register's current output, and loads the IF/ID pipeline register that feeds decode. It also handles stalls from the hazard unit, redirects from branch resolution, and variable-latency memory responses.

## Interface
Parameters:
- ADDR_W, 64, PC and address width.
- INSTR_W, 32, instruction width.
- RESET_PC, 64'h0, PC value driven while in reset and in IDLE.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low. While low, all state and outputs take their reset values immediately. The top level drives the PC register's active-high reset with ~reset.
- pc_q  in  ADDR_W  current PC, from the PC register output.
- pc_d  out  ADDR_W  next PC, to the PC register input (combinational).
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address; always equals pc_q.
- imem_ack  in  1  response valid; meaningful only while imem_req=1.
- imem_rdata  in  INSTR_W  fetched instruction; valid with imem_ack.
- stall  in  1  hazard unit: hold IF/ID and PC.
- redirect  in  1  branch taken or mispredict: flush and jump.
- redirect_pc  in  ADDR_W  redirect target.
- if_id_valid  out  1  IF/ID holds a live instruction.
- if_id_pc  out  ADDR_W  PC of the IF/ID instruction.
- if_id_pc4  out  ADDR_W  if_id_pc + 4.
- if_id_instr  out  INSTR_W  instruction.
- fetch_cnt  out  32  count of instructions loaded into IF/ID.

## Operation
- FSM has 3 states:
  - IDLE: first cycle after reset release.
  - REQ: fetching.
  - HOLD: instruction captured while stalled.
- Reset values:
  - state = IDLE.
  - if_id_valid = 0; if_id_pc, if_id_pc4, if_id_instr = 0.
  - fetch_cnt = 0; skid buffer empty.
  - imem_req = 0; pc_d = RESET_PC.
- IDLE: imem_req = 0 and pc_d = RESET_PC. Next state is REQ.
- REQ: imem_req = 1.
  - ack=1, stall=0: load IF/ID with {valid=1, pc_q, pc_q+4, imem_rdata}; pc_d = pc_q+4; fetch_cnt += 1.
  - ack=1, stall=1: IF/ID held; instruction and pc_q go into the skid buffer; pc_d = pc_q; next state HOLD.
  - ack=0, stall=0: if_id_valid <= 0 (bubble); pc_d = pc_q.
  - ack=0, stall=1: IF/ID held; pc_d = pc_q.
- HOLD: imem_req = 0.
  - stall=1: everything is held; pc_d = pc_q.
  - stall=0: load IF/ID from the skid buffer; pc_d = skid pc + 4; fetch_cnt += 1; next state REQ.
- redirect has the highest priority in any state, overriding stall and ack:
  - pc_d = {redirect_pc[ADDR_W-1:2], 2'b00}.
  - if_id_valid <= 0.
  - skid buffer cleared.
  - Any same-cycle imem_ack/imem_rdata is discarded and fetch_cnt does not increment.
  - Next state REQ.
- A request in flight may be abandoned only by redirect. The memory must accept a new address on the next cycle.
- Arithmetic: PC+4 is modulo 2^ADDR_W, so 64'hFFFF_FFFF_FFFF_FFFC + 4 = 0. fetch_cnt wraps from 2^32-1 to 0.
- When if_id_valid = 0 the other IF/ID fields are don't-care, but they must hold their last values and not go X.

## Timing
- pc_d, imem_req and imem_addr are combinational from state, pc_q and the inputs. There is no path from imem_rdata to pc_d.
- Zero-wait memory (ack in the same cycle as req): one instruction per cycle; IF/ID updates on the same posedge as the PC register.
- N-cycle memory latency gives N bubbles (if_id_valid = 0) per instruction.
- Redirect in cycle t: the PC register holds the target after posedge t. The first IF/ID load from the target happens at posedge t+1 at the earliest.
- Stall release from HOLD: IF/ID is loaded at that posedge and the next fetch is requested in the following cycle.
- Reset asserted mid-operation: outputs go to their reset values asynchronously. The in-flight request is dropped and not replayed.

## Test plan
- Reset then zero-wait memory returning pc-derived words, with RESET_PC=0: if_id_pc sequence 0, 4, 8, 12 on consecutive cycles; fetch_cnt = 4 after 4 loads.
- Memory with 2-cycle latency: if_id_valid pattern 0,0,1 repeating; pc_d is held at pc_q during the wait cycles.
- Ack at pc=0x10 with stall held high 3 cycles: state HOLD, IF/ID unchanged, imem_req=0. On stall release IF/ID gets pc 0x10; the next request address is 0x14.
- redirect=1 with redirect_pc=0x1003 together with ack and stall=1: ack discarded, if_id_valid=0, fetch_cnt unchanged, next imem_addr=0x1000.
- redirect_pc=64'hFFFF_FFFF_FFFF_FFFC with zero-wait memory: if_id_pc4=0 and the next fetch address is 0.
- Reset pulled low while in HOLD: outputs are immediately at reset values. After release there is one IDLE cycle, then a fetch from RESET_PC.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory fetch port: fetch stage is master, memory is slave.
// Request is level-held until ack or until the fetch stage abandons it on redirect.
interface fetch_stage_if #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch around an external PC register; zero-wait memory loads IF/ID every cycle.
// Stall holds PC and IF/ID (a response landing under stall parks in a one-entry skid); redirect beats all.
module fetch_stage #(
    parameter int                ADDR_W   = 64,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_q,
    output logic [ADDR_W-1:0]  pc_d,
    fetch_stage_if.master      imem,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               if_id_valid,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [ADDR_W-1:0]  if_id_pc4,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [31:0]        fetch_cnt
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t state, state_n;

    logic               skid_vld;
    logic [ADDR_W-1:0]  skid_pc;
    logic [INSTR_W-1:0] skid_instr;

    logic [ADDR_W-1:0] pc_q4;
    logic [ADDR_W-1:0] skid_pc4;
    logic              ld_mem, ld_skid, capture, bubble, flush;
    logic              unused_redirect_lsbs;

    assign pc_q4                = pc_q + ADDR_W'(4);
    assign skid_pc4             = skid_pc + ADDR_W'(4);
    assign imem.imem_addr       = pc_q;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    always_comb begin
        state_n       = state;
        pc_d          = pc_q;
        imem.imem_req = 1'b0;
        ld_mem        = 1'b0;
        ld_skid       = 1'b0;
        capture       = 1'b0;
        bubble        = 1'b0;
        flush         = 1'b0;
        if (!reset) begin
            pc_d = RESET_PC;
        end else if (redirect) begin
            // Any in-flight request is abandoned; same-cycle ack is simply ignored.
            imem.imem_req = (state == REQ);
            pc_d          = {redirect_pc[ADDR_W-1:2], 2'b00};
            flush         = 1'b1;
            state_n       = REQ;
        end else begin
            case (state)
                IDLE: begin
                    pc_d    = RESET_PC;
                    state_n = REQ;
                end
                REQ: begin
                    imem.imem_req = 1'b1;
                    if (imem.imem_ack && !stall) begin
                        ld_mem = 1'b1;
                        pc_d   = pc_q4;
                    end else if (imem.imem_ack) begin
                        capture = 1'b1;
                        state_n = HOLD;
                    end else if (!stall) begin
                        bubble = 1'b1;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ld_skid = 1'b1;
                        pc_d    = skid_pc4;
                        state_n = REQ;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_pc4   <= '0;
            if_id_instr <= '0;
            fetch_cnt   <= '0;
            skid_vld    <= 1'b0;
            skid_pc     <= '0;
            skid_instr  <= '0;
        end else begin
            state <= state_n;
            if (flush) begin
                if_id_valid <= 1'b0;
                skid_vld    <= 1'b0;
            end else if (ld_mem) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= pc_q;
                if_id_pc4   <= pc_q4;
                if_id_instr <= imem.imem_rdata;
                fetch_cnt   <= fetch_cnt + 32'd1;
            end else if (capture) begin
                skid_vld   <= 1'b1;
                skid_pc    <= pc_q;
                skid_instr <= imem.imem_rdata;
            end else if (ld_skid) begin
                if_id_valid <= skid_vld;
                if_id_pc    <= skid_pc;
                if_id_pc4   <= skid_pc4;
                if_id_instr <= skid_instr;
                skid_vld    <= 1'b0;
                if (skid_vld) begin
                    fetch_cnt <= fetch_cnt + 32'd1;
                end
            end else if (bubble) begin
                if_id_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: PC register and latency-programmable memory model around the DUT,
// scoreboard of accepted responses checked on each IF/ID load, plus directed checks.
module tb_fetch_stage;
    localparam int          ADDR_W   = 64;
    localparam int          INSTR_W  = 32;
    localparam logic [63:0] RESET_PC = 64'h0;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] pc4;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] pc_q, pc_d;
    logic        stall, redirect;
    logic [63:0] redirect_pc;
    logic        if_id_valid;
    logic [63:0] if_id_pc, if_id_pc4;
    logic [31:0] if_id_instr, fetch_cnt;

    int   lat = 0;
    int   lat_cnt;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sbq[$];
    logic pend_hold = 1'b0;
    logic [31:0] prev_cnt = '0;

    fetch_stage_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) mem_if ();

    fetch_stage #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_q        (pc_q),
        .pc_d        (pc_d),
        .imem        (mem_if),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_id_valid (if_id_valid),
        .if_id_pc    (if_id_pc),
        .if_id_pc4   (if_id_pc4),
        .if_id_instr (if_id_instr),
        .fetch_cnt   (fetch_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_0000;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end

    // Memory acks once the request has been held for lat cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                                lat_cnt <= 0;
        else if (!mem_if.imem_req || mem_if.imem_ack || redirect)  lat_cnt <= 0;
        else                                                       lat_cnt <= lat_cnt + 1;
    end
    assign mem_if.imem_ack   = mem_if.imem_req && (lat_cnt >= lat);
    assign mem_if.imem_rdata = mem_word(mem_if.imem_addr);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Push every accepted response shortly before the edge that consumes it.
    always @(negedge clk) begin
        #4;
        if (!reset) begin
            sbq.delete();
            pend_hold = 1'b0;
        end else if (redirect) begin
            if (pend_hold) void'(sbq.pop_back());
            pend_hold = 1'b0;
        end else if (mem_if.imem_req && mem_if.imem_ack) begin
            sbq.push_back('{pc: pc_q, pc4: pc_q + 64'd4, instr: mem_word(pc_q)});
            pend_hold = stall;
        end else if (!stall) begin
            pend_hold = 1'b0;
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (reset && fetch_cnt != prev_cnt) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_load", 64'd1, 64'd0);
            end else begin
                e = sbq.pop_front();
                chk("sb_valid", {63'd0, if_id_valid}, 64'd1);
                chk("sb_pc",    if_id_pc,  e.pc);
                chk("sb_pc4",   if_id_pc4, e.pc4);
                chk("sb_instr", {32'd0, if_id_instr}, {32'd0, e.instr});
            end
        end
        prev_cnt = fetch_cnt;
    end

    initial begin
        reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", {63'd0, if_id_valid}, 64'd0);
        chk("rst_cnt",   {32'd0, fetch_cnt}, 64'd0);
        chk("rst_req",   {63'd0, mem_if.imem_req}, 64'd0);
        chk("rst_pcd",   pc_d, RESET_PC);

        // Zero-wait stream
        @(negedge clk); reset = 1'b1; #1;
        chk("idle_req", {63'd0, mem_if.imem_req}, 64'd0);
        chk("idle_pcd", pc_d, RESET_PC);
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("zw_pc",    if_id_pc, 64'(4 * i));
            chk("zw_valid", {63'd0, if_id_valid}, 64'd1);
        end
        chk("zw_cnt4", {32'd0, fetch_cnt}, 64'd4);

        // Two-cycle latency
        @(negedge clk); lat = 2; #1;
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 3; j++) begin
                chk("lat_pcd",   pc_d, (j == 2) ? 64'(16 + 4 * r + 4) : 64'(16 + 4 * r));
                chk("lat_addr",  mem_if.imem_addr, 64'(16 + 4 * r));
                @(posedge clk); #1;
                chk("lat_valid", {63'd0, if_id_valid}, (j == 2) ? 64'd1 : 64'd0);
                @(negedge clk); #1;
            end
        end
        chk("lat_cnt7", {32'd0, fetch_cnt}, 64'd7);

        // Stall over an ack at 0x10
        lat = 0; redirect = 1'b1; redirect_pc = 64'h10; #1;
        chk("rd10_pcd", pc_d, 64'h10);
        @(posedge clk); #1;
        chk("rd10_valid", {63'd0, if_id_valid}, 64'd0);
        @(negedge clk); redirect = 1'b0; stall = 1'b1; #1;
        chk("st_addr", mem_if.imem_addr, 64'h10);
        chk("st_ack",  {63'd0, mem_if.imem_ack}, 64'd1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            chk("hold_req",   {63'd0, mem_if.imem_req}, 64'd0);
            chk("hold_valid", {63'd0, if_id_valid}, 64'd0);
            chk("hold_pc",    if_id_pc, 64'd24);
            chk("hold_pcd",   pc_d, 64'h10);
            chk("hold_cnt",   {32'd0, fetch_cnt}, 64'd7);
        end
        @(negedge clk); stall = 1'b0; #1;
        chk("rel_pcd", pc_d, 64'h14);
        @(posedge clk); #1;
        chk("rel_pc",    if_id_pc,  64'h10);
        chk("rel_pc4",   if_id_pc4, 64'h14);
        chk("rel_valid", {63'd0, if_id_valid}, 64'd1);
        chk("rel_cnt",   {32'd0, fetch_cnt}, 64'd8);
        @(negedge clk); #1;
        chk("rel_req",  {63'd0, mem_if.imem_req}, 64'd1);
        chk("rel_addr", mem_if.imem_addr, 64'h14);

        // Redirect beats ack and stall
        stall = 1'b1; redirect = 1'b1; redirect_pc = 64'h1003; #1;
        chk("rd_pcd", pc_d, 64'h1000);
        @(posedge clk); #1;
        chk("rd_valid", {63'd0, if_id_valid}, 64'd0);
        chk("rd_cnt",   {32'd0, fetch_cnt}, 64'd8);
        @(negedge clk); stall = 1'b0; redirect = 1'b0; #1;
        chk("rd_req",  {63'd0, mem_if.imem_req}, 64'd1);
        chk("rd_addr", mem_if.imem_addr, 64'h1000);
        @(posedge clk); #1;
        chk("rd_tgt_pc", if_id_pc, 64'h1000);
        chk("rd_cnt9",   {32'd0, fetch_cnt}, 64'd9);

        // PC+4 wraps at the top of the address space
        @(negedge clk); redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        @(posedge clk); #1;
        @(negedge clk); redirect = 1'b0; #1;
        chk("wrap_addr", mem_if.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_pcd",  pc_d, 64'h0);
        @(posedge clk); #1;
        chk("wrap_pc",  if_id_pc,  64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_pc4", if_id_pc4, 64'h0);
        @(negedge clk); #1;
        chk("wrap_next_addr", mem_if.imem_addr, 64'h0);

        // Reset while holding
        stall = 1'b1;
        @(negedge clk); #1;
        chk("rh_req", {63'd0, mem_if.imem_req}, 64'd0);
        #1 reset = 1'b0; #1;
        chk("rh_valid", {63'd0, if_id_valid}, 64'd0);
        chk("rh_cnt",   {32'd0, fetch_cnt}, 64'd0);
        chk("rh_req0",  {63'd0, mem_if.imem_req}, 64'd0);
        chk("rh_pcd",   pc_d, RESET_PC);
        chk("rh_pc",    if_id_pc, 64'd0);
        chk("rh_pc4",   if_id_pc4, 64'd0);
        chk("rh_instr", {32'd0, if_id_instr}, 64'd0);
        stall = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1; #1;
        chk("rh_idle_req", {63'd0, mem_if.imem_req}, 64'd0);
        chk("rh_idle_pcd", pc_d, RESET_PC);
        @(posedge clk); #1;
        chk("rh_fetch_req",  {63'd0, mem_if.imem_req}, 64'd1);
        chk("rh_fetch_addr", mem_if.imem_addr, RESET_PC);
        @(posedge clk); #2;
        chk("rh_load_pc",  if_id_pc, RESET_PC);
        chk("rh_load_cnt", {32'd0, fetch_cnt}, 64'd1);
        chk("sb_drain",    64'(sbq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
